// File: rtl/e_io_cfg_pkg.sv
// e_io_cfg_pkg: shared definitions for the east-edge IO tile.
//   MODE_*     : 2-bit per-channel mode encodings
//   MODE_W     : width of one channel's mode field
//   settle_len : number of gated cycles after a mode change
package e_io_cfg_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_BYPASS = 2'b00;
  localparam logic [MODE_W-1:0] MODE_REG    = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SYNC   = 2'b10;
  localparam logic [MODE_W-1:0] MODE_DIS    = 2'b11;

  // Long enough for the deepest (SYNC) path to refill after a flush.
  function automatic int unsigned settle_len(input int unsigned sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/e_io_cfg_channel.sv
// e_io_cfg_channel: one IO channel with its datapath flops, pad->fabric
// synchroniser and post-mode-change settle counter.
//   clk, rst      : tile clock, synchronous active-high reset
//   mode          : current registered mode of this channel
//   mode_changed  : a cfg load at this edge changes this channel's mode
//   from_fabric   : fabric->pad data in       e_out     : pad output
//   e_in          : pad->fabric data in       to_fabric : fabric output
//   busy          : channel is settling (outputs gated low)
module e_io_cfg_channel
  import e_io_cfg_pkg::*;
#(
  parameter int unsigned CH_WIDTH    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MODE_W-1:0]   mode,
  input  logic                mode_changed,
  input  logic [CH_WIDTH-1:0] from_fabric,
  input  logic [CH_WIDTH-1:0] e_in,
  output logic [CH_WIDTH-1:0] to_fabric,
  output logic [CH_WIDTH-1:0] e_out,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(settle_len(SYNC_STAGES));

  logic [CH_WIDTH-1:0] p2f_q [SYNC_STAGES];
  logic [CH_WIDTH-1:0] p2f_d [SYNC_STAGES];
  logic [CH_WIDTH-1:0] f2p_q;
  logic [CH_WIDTH-1:0] f2p_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;

  // Next-state: flush on change, hold zero when disabled, else shift.
  // The pad->fabric chain shifts in REG too; REG taps stage 0, SYNC the last.
  always_comb begin
    cnt_d = cnt_q;
    f2p_d = f2p_q;
    for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
      p2f_d[i] = p2f_q[i];
    end

    if (mode_changed) begin
      cnt_d = SETTLE_LOAD;
      f2p_d = '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        p2f_d[i] = '0;
      end
    end else begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      if (mode == MODE_DIS) begin
        f2p_d = '0;
        for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
          p2f_d[i] = '0;
        end
      end else begin
        f2p_d    = from_fabric;
        p2f_d[0] = e_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
          p2f_d[i] = p2f_q[i-1];
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      f2p_q <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        p2f_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      f2p_q <= f2p_d;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        p2f_q[i] <= p2f_d[i];
      end
    end
  end

  assign busy = (cnt_q != '0);

  // Output select; bypass is a pure wire so outputs cannot be registered.
  always_comb begin
    to_fabric = '0;
    e_out     = '0;
    if (!busy) begin
      case (mode)
        MODE_BYPASS: begin
          to_fabric = e_in;
          e_out     = from_fabric;
        end
        MODE_REG: begin
          to_fabric = p2f_q[0];
          e_out     = f2p_q;
        end
        MODE_SYNC: begin
          to_fabric = p2f_q[SYNC_STAGES-1];
          e_out     = f2p_q;
        end
        default: begin
          to_fabric = '0;
          e_out     = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/e_io_cfg_reg.sv
// e_io_cfg_reg: east-edge IO tile with frame-configured per-channel modes.
//   UserCLK, UserRST          : tile clock, synchronous active-high reset
//   from_fabric -> E_out      : fabric->pad data, NUM_CH x CH_WIDTH
//   E_in -> to_fabric         : pad->fabric data, NUM_CH x CH_WIDTH
//   FrameData, FrameStrobe    : configuration frame inputs
//   FrameData_o, FrameStrobe_o, UserCLK_o : pass-through to neighbour tile
//   cfg_busy                  : any channel settling after a mode change
module e_io_cfg_reg
  import e_io_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned CH_WIDTH        = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned CFG_FRAME       = 0
) (
  input  logic                         UserCLK,
  input  logic                         UserRST,
  input  logic [NUM_CH*CH_WIDTH-1:0]   from_fabric,
  output logic [NUM_CH*CH_WIDTH-1:0]   to_fabric,
  input  logic [NUM_CH*CH_WIDTH-1:0]   E_in,
  output logic [NUM_CH*CH_WIDTH-1:0]   E_out,
  input  logic [FrameBitsPerRow-1:0]   FrameData,
  input  logic [MaxFramesPerCol-1:0]   FrameStrobe,
  output logic [FrameBitsPerRow-1:0]   FrameData_o,
  output logic [MaxFramesPerCol-1:0]   FrameStrobe_o,
  output logic                         UserCLK_o,
  output logic                         cfg_busy
);

  localparam int unsigned CFG_W = MODE_W * NUM_CH;

  logic [CFG_W-1:0]  cfg_q;
  logic [CFG_W-1:0]  cfg_new;
  logic              cfg_load;
  logic [NUM_CH-1:0] mode_changed;
  logic [NUM_CH-1:0] ch_busy;

  assign cfg_load = FrameStrobe[CFG_FRAME];
  assign cfg_new  = FrameData[CFG_W-1:0];

  // Mode register; reset wins over a simultaneous strobe.
  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      cfg_q <= {NUM_CH{MODE_DIS}};
    end else if (cfg_load) begin
      cfg_q <= cfg_new;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Identical reloads do not disturb a channel.
    assign mode_changed[c] = cfg_load &&
        (cfg_new[c*MODE_W +: MODE_W] != cfg_q[c*MODE_W +: MODE_W]);

    e_io_cfg_channel #(
      .CH_WIDTH    (CH_WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk          (UserCLK),
      .rst          (UserRST),
      .mode         (cfg_q[c*MODE_W +: MODE_W]),
      .mode_changed (mode_changed[c]),
      .from_fabric  (from_fabric[c*CH_WIDTH +: CH_WIDTH]),
      .e_in         (E_in[c*CH_WIDTH +: CH_WIDTH]),
      .to_fabric    (to_fabric[c*CH_WIDTH +: CH_WIDTH]),
      .e_out        (E_out[c*CH_WIDTH +: CH_WIDTH]),
      .busy         (ch_busy[c])
    );
  end

  assign cfg_busy      = |ch_busy;
  assign FrameData_o   = FrameData;
  assign FrameStrobe_o = FrameStrobe;
  assign UserCLK_o     = UserCLK;

endmodule

// File: tb/tb_e_io_cfg_reg.sv
// tb_e_io_cfg_reg: directed test-plan scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the tile.
module tb_e_io_cfg_reg;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned CH_WIDTH    = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FBR         = 32;
  localparam int unsigned MFC         = 20;
  localparam int unsigned CFG_FRAME   = 0;
  localparam int unsigned DW          = NUM_CH * CH_WIDTH;
  localparam int          SETTLE      = SYNC_STAGES + 1;

  logic           UserCLK = 1'b0;
  logic           UserRST;
  logic [DW-1:0]  from_fabric, to_fabric, E_in, E_out;
  logic [FBR-1:0] FrameData, FrameData_o;
  logic [MFC-1:0] FrameStrobe, FrameStrobe_o;
  logic           UserCLK_o, cfg_busy;

  always #5 UserCLK = ~UserCLK;

  e_io_cfg_reg #(
    .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .SYNC_STAGES(SYNC_STAGES),
    .FrameBitsPerRow(FBR), .MaxFramesPerCol(MFC), .CFG_FRAME(CFG_FRAME)
  ) dut (
    .UserCLK(UserCLK), .UserRST(UserRST),
    .from_fabric(from_fabric), .to_fabric(to_fabric),
    .E_in(E_in), .E_out(E_out),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .FrameData_o(FrameData_o), .FrameStrobe_o(FrameStrobe_o),
    .UserCLK_o(UserCLK_o), .cfg_busy(cfg_busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode per channel, gated cycles remaining, input history by edge.
  logic [1:0]    m_mode [NUM_CH];
  int            m_left [NUM_CH];
  logic [DW-1:0] hist_e [$];
  logic [DW-1:0] hist_f [$];

  function automatic logic [CH_WIDTH-1:0] get(input logic [DW-1:0] v, input int c);
    return v[c*CH_WIDTH +: CH_WIDTH];
  endfunction

  function automatic logic [DW-1:0] put(input logic [DW-1:0] v, input int c,
                                        input logic [CH_WIDTH-1:0] b);
    logic [DW-1:0] r;
    r = v;
    r[c*CH_WIDTH +: CH_WIDTH] = b;
    return r;
  endfunction

  function automatic logic [2*NUM_CH-1:0] model_cfg();
    logic [2*NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[2*c +: 2] = m_mode[c];
    return r;
  endfunction

  // Apply what the tile sees at a rising edge.
  task automatic model_edge();
    logic [1:0] nm;
    hist_e.push_front(E_in);
    hist_f.push_front(from_fabric);
    if (hist_e.size() > 4) hist_e.delete(hist_e.size() - 1);
    if (hist_f.size() > 4) hist_f.delete(hist_f.size() - 1);
    for (int c = 0; c < NUM_CH; c++) begin
      if (UserRST) begin
        m_mode[c] = 2'd3;
        m_left[c] = 0;
      end else begin
        if (m_left[c] > 0) m_left[c]--;
        if (FrameStrobe[CFG_FRAME]) begin
          nm = FrameData[2*c +: 2];
          if (nm != m_mode[c]) begin
            m_mode[c] = nm;
            m_left[c] = SETTLE;
          end
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [DW-1:0] etf, eeo;
    logic          ebusy;
    etf = '0; eeo = '0; ebusy = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_left[c] != 0) ebusy = 1'b1;
      else begin
        case (m_mode[c])
          2'd0: begin etf = put(etf, c, get(E_in, c));       eeo = put(eeo, c, get(from_fabric, c)); end
          2'd1: begin etf = put(etf, c, get(hist_e[0], c));  eeo = put(eeo, c, get(hist_f[0], c)); end
          2'd2: begin etf = put(etf, c, get(hist_e[SYNC_STAGES-1], c)); eeo = put(eeo, c, get(hist_f[0], c)); end
          default: ;
        endcase
      end
    end
    chk({tag, "/to_fabric"}, 64'(to_fabric), 64'(etf));
    chk({tag, "/E_out"}, 64'(E_out), 64'(eeo));
    chk({tag, "/cfg_busy"}, 64'(cfg_busy), 64'(ebusy));
    chk({tag, "/FrameData_o"}, 64'(FrameData_o), 64'(FrameData));
    chk({tag, "/FrameStrobe_o"}, 64'(FrameStrobe_o), 64'(FrameStrobe));
    chk({tag, "/UserCLK_o"}, 64'(UserCLK_o), 64'(UserCLK));
  endtask

  // Entered just after a falling edge with inputs driven; returns at the next one.
  task automatic cycle(input string tag);
    #1 check_outputs(tag);
    @(posedge UserCLK);
    model_edge();
    @(negedge UserCLK);
  endtask

  task automatic load_cfg(input logic [2*NUM_CH-1:0] cfg, input string tag);
    FrameData = FBR'($urandom());
    FrameData[2*NUM_CH-1:0] = cfg;
    FrameStrobe = '0;
    FrameStrobe[CFG_FRAME] = 1'b1;
    cycle(tag);
    FrameStrobe = '0;
  endtask

  initial begin
    logic [2*NUM_CH-1:0] cur, flip;
    for (int c = 0; c < NUM_CH; c++) begin m_mode[c] = 2'd3; m_left[c] = 0; end
    for (int i = 0; i < 4; i++) begin hist_e.push_back('0); hist_f.push_back('0); end

    // 1. Reset with strobe and all-ones data: strobe must be ignored.
    UserRST = 1'b1; E_in = '1; from_fabric = '1;
    FrameData = '0; FrameStrobe = '0; FrameStrobe[CFG_FRAME] = 1'b1;
    @(posedge UserCLK); model_edge(); @(negedge UserCLK);
    cycle("rst");
    UserRST = 1'b0; FrameStrobe = '0;
    #1 chk("rst_busy", 64'(cfg_busy), 64'd0);
    chk("rst_to_fabric", 64'(to_fabric), 64'd0);
    chk("rst_E_out", 64'(E_out), 64'd0);
    cycle("post_rst");
    cycle("post_rst");

    // 2. Bypass: 3-cycle settle, then zero-latency both ways.
    E_in = '0; from_fabric = '0;
    load_cfg(8'h00, "bp_load");
    for (int k = 0; k < 4; k++) begin
      #1 chk("bp_busy", 64'(cfg_busy), 64'(k < SETTLE));
      cycle("bp_settle");
    end
    E_in = put(E_in, 0, 8'hA5); from_fabric = put(from_fabric, 2, 8'h3C);
    #1 chk("bp_tf0", 64'(get(to_fabric, 0)), 64'hA5);
    chk("bp_eo2", 64'(get(E_out, 2)), 64'h3C);
    cycle("bypass");

    // 3. ch0 REG, ch1 SYNC: latencies 1 and 2.
    E_in = '0; from_fabric = '0;
    load_cfg(8'hF9, "rs_load");
    for (int k = 0; k < 5; k++) cycle("rs_settle");
    E_in = put(E_in, 0, 8'h5A); E_in = put(E_in, 1, 8'h5A);
    from_fabric = put(from_fabric, 1, 8'hC3);
    #1 chk("rs_t_tf0", 64'(get(to_fabric, 0)), 64'h00);
    cycle("rs_t");
    #1 chk("rs_t1_tf0", 64'(get(to_fabric, 0)), 64'h5A);
    chk("rs_t1_tf1", 64'(get(to_fabric, 1)), 64'h00);
    chk("rs_t1_eo1", 64'(get(E_out, 1)), 64'hC3);
    cycle("rs_t1");
    #1 chk("rs_t2_tf1", 64'(get(to_fabric, 1)), 64'h5A);
    cycle("rs_t2");

    // 4. Settle gating of ch0 only; ch1 keeps flowing.
    E_in = put(E_in, 0, 8'hFF); from_fabric = put(from_fabric, 0, 8'hFF);
    E_in = put(E_in, 1, 8'h77);
    for (int k = 0; k < 3; k++) cycle("gate_pre");
    #1 chk("gate_pre_tf0", 64'(get(to_fabric, 0)), 64'hFF);
    load_cfg(8'hFA, "gate_load");
    for (int k = 0; k < 4; k++) begin
      #1 chk("gate_busy", 64'(cfg_busy), 64'(k < SETTLE));
      chk("gate_tf0", 64'(get(to_fabric, 0)), (k < SETTLE) ? 64'h00 : 64'hFF);
      chk("gate_tf1", 64'(get(to_fabric, 1)), 64'h77);
      cycle("gate");
    end

    // 5. Identical reload: no gap. Then two changes one cycle apart.
    load_cfg(8'hFA, "same_load");
    #1 chk("same_busy", 64'(cfg_busy), 64'd0);
    chk("same_tf0", 64'(get(to_fabric, 0)), 64'hFF);
    cycle("same");
    load_cfg(8'hF8, "dbl_load1");
    #1 chk("dbl_busy_first", 64'(cfg_busy), 64'd1);
    load_cfg(8'hF9, "dbl_load2");
    for (int k = 0; k < 4; k++) begin
      #1 chk("dbl_busy", 64'(cfg_busy), 64'(k < SETTLE));
      cycle("dbl");
    end

    // 6. Reset on the second settle cycle.
    load_cfg(8'hFA, "mr_load");
    cycle("mr_settle1");
    UserRST = 1'b1;
    cycle("mr_rst");
    UserRST = 1'b0;
    #1 chk("mr_busy", 64'(cfg_busy), 64'd0);
    chk("mr_tf", 64'(to_fabric), 64'd0);
    chk("mr_eo", 64'(E_out), 64'd0);
    cycle("mr_post");

    // Random traffic with identical, single-channel and random reloads.
    for (int n = 0; n < 1500; n++) begin
      E_in = DW'($urandom()); from_fabric = DW'($urandom());
      UserRST = ($urandom_range(0, 99) == 0);
      FrameData = FBR'($urandom());
      FrameStrobe = MFC'($urandom());
      FrameStrobe[CFG_FRAME] = ($urandom_range(0, 3) == 0);
      cur = model_cfg();
      flip = 8'h03;
      flip = flip << (2 * $urandom_range(0, NUM_CH - 1));
      case ($urandom_range(0, 2))
        0: FrameData[2*NUM_CH-1:0] = cur;
        1: FrameData[2*NUM_CH-1:0] = cur ^ (flip & 8'(FrameData[2*NUM_CH-1:0]));
        default: ;
      endcase
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
